// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants for the fetch front end.
//   XLEN     - address/data width of the core
//   ILEN     - instruction word width
//   NOP_INST - canonical NOP (addi x0,x0,0), shown on inst when nothing is buffered
//   PC_STEP  - byte increment between sequential fetches
`timescale 1ns/100ps
package riscv_pkg;
   localparam int unsigned XLEN     = 32;
   localparam int unsigned ILEN     = 32;
   localparam logic [31:0] NOP_INST = 32'h0000_0013;
   localparam int unsigned PC_STEP  = 4;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush, used for the {pc,inst} buffer and the
// PC-tag queue of the fetch unit. DEPTH must be a power of two (pointers wrap naturally).
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - empties the FIFO; overrides push and pop in the same cycle
//   push/push_data - write an entry (allowed when full only together with pop)
//   pop         - remove the head entry (ignored when empty)
//   head        - current head entry (undefined contents when empty)
//   count, full, empty - occupancy status
`timescale 1ns/100ps
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   always_comb begin
      do_pop   = pop && !empty && !flush;
      // a pop in the same cycle frees the slot a push into a full FIFO needs
      do_push  = push && (!full || do_pop) && !flush;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage needs no reset: entries are only visible once counted
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full && !pop && !flush));
   a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
      !(pop && empty && !flush));
endmodule

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: fetch stage feeding decode / register bank.
// Holds the PC, issues in-order word fetches over valid/ready, pairs each response with
// its issued PC through a tag queue, and buffers {pc,inst} in a FIFO. A one-cycle
// redirect reloads the PC and flushes everything fetched or still in flight.
//   clk, rst_n                     - clock, asynchronous active-low reset
//   redirect_valid, redirect_pc    - branch/jump target (bits[1:0] ignored)
//   imem_req_valid/ready, imem_addr - fetch request channel (address = PC)
//   imem_rsp_valid, imem_rsp_data  - in-order read data, >=1 cycle after accept
//   inst_valid/ready, inst, inst_pc - buffered instruction toward decode
`timescale 1ns/100ps
module inst_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN     = riscv_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int unsigned     DEPTH    = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [ILEN-1:0] imem_rsp_data,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic [ILEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc
);
   localparam int unsigned     CW          = $clog2(DEPTH) + 1;
   localparam int unsigned     EW          = XLEN + ILEN;
   localparam logic [XLEN-1:0] RESET_PC_AL = RESET_PC & ~XLEN'(3);

   typedef logic [CW-1:0] cnt_t;

   logic [XLEN-1:0] pc_q, pc_d;
   cnt_t            inflight_q, inflight_d;
   cnt_t            drop_q, drop_d;

   logic            accept, rsp_keep, rsp_drop, pop_ok;
   logic [CW:0]     credit_used;

   logic [EW-1:0]   data_head;
   cnt_t            data_count;
   logic            data_full, data_empty;
   logic [XLEN-1:0] tag_head;
   cnt_t            tag_count;
   logic            tag_full, tag_empty;

   assign accept   = imem_req_valid && imem_req_ready;
   assign rsp_keep = imem_rsp_valid && (drop_q == '0);
   assign rsp_drop = imem_rsp_valid && (drop_q != '0);
   assign pop_ok   = inst_valid && inst_ready && !redirect_valid;

   // A pop this cycle returns its slot before any new response can land,
   // so it already counts as free credit for the request issued now.
   assign credit_used    = {1'b0, inflight_q} + {1'b0, data_count} - (CW+1)'(pop_ok);
   assign imem_req_valid = rst_n && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
   assign imem_addr      = pc_q;

   always_comb begin
      pc_d       = pc_q;
      inflight_d = inflight_q;
      drop_d     = drop_q;
      if (redirect_valid) begin
         pc_d       = redirect_pc & ~XLEN'(3);
         inflight_d = '0;
         // a response this cycle retires one outstanding word either way
         drop_d     = drop_q + inflight_q - cnt_t'(imem_rsp_valid);
      end else begin
         if (accept) pc_d = pc_q + XLEN'(PC_STEP);
         inflight_d = inflight_q + cnt_t'(accept) - cnt_t'(rsp_keep);
         if (rsp_drop) drop_d = drop_q - cnt_t'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= RESET_PC_AL;
         inflight_q <= '0;
         drop_q     <= '0;
      end else begin
         pc_q       <= pc_d;
         inflight_q <= inflight_d;
         drop_q     <= drop_d;
      end
   end

   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (DEPTH)
   ) u_tag_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (accept),
      .push_data (pc_q),
      .pop       (rsp_keep),
      .head      (tag_head),
      .count     (tag_count),
      .full      (tag_full),
      .empty     (tag_empty)
   );

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_inst_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect_valid),
      .push      (rsp_keep && !redirect_valid),
      .push_data ({tag_head, imem_rsp_data}),
      .pop       (pop_ok),
      .head      (data_head),
      .count     (data_count),
      .full      (data_full),
      .empty     (data_empty)
   );

   assign inst_valid = !data_empty;
   assign inst       = data_empty ? NOP_INST : data_head[ILEN-1:0];
   assign inst_pc    = data_empty ? '0 : data_head[EW-1:ILEN];

   a_rsp_expected: assert property (@(posedge clk) disable iff (!rst_n)
      !(imem_rsp_valid && inflight_q == '0 && drop_q == '0));
   a_tag_tracks_inflight: assert property (@(posedge clk) disable iff (!rst_n)
      tag_count == inflight_q);
   a_tag_room: assert property (@(posedge clk) disable iff (!rst_n)
      !(accept && tag_full));
   a_tag_present: assert property (@(posedge clk) disable iff (!rst_n)
      !(rsp_keep && tag_empty));
   a_buf_room: assert property (@(posedge clk) disable iff (!rst_n)
      !(rsp_keep && !redirect_valid && data_full && !pop_ok));
endmodule
